// File: rtl/div_ctrl_pkg.sv
// Shared widths, opcodes and state encoding for the EX-stage divider sequencer.
package div_ctrl_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  typedef enum logic [1:0] {
    DIV_CTRL_IDLE  = 2'b00,
    DIV_CTRL_BUSY  = 2'b01,
    DIV_CTRL_HOLD  = 2'b10,
    DIV_CTRL_ABORT = 2'b11
  } div_ctrl_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle between the EX pipeline, the divider and div_ctrl.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic [7:0]        aluop;
  logic [REG_W-1:0]  reg1;
  logic [REG_W-1:0]  reg2;
  logic              flush;
  logic              ex_stall;
  logic [DREG_W-1:0] div_result;
  logic              div_ready;

  logic [REG_W-1:0]  div_opdata1;
  logic [REG_W-1:0]  div_opdata2;
  logic              div_start;
  logic              div_annul;
  logic              signed_div;
  logic              stallreq;
  logic              whilo;
  logic [REG_W-1:0]  hi;
  logic [REG_W-1:0]  lo;

  // master: pipeline + divider side; slave: the sequencer
  modport master (
    output aluop, reg1, reg2, flush, ex_stall, div_result, div_ready,
    input  div_opdata1, div_opdata2, div_start, div_annul, signed_div,
           stallreq, whilo, hi, lo
  );

  modport slave (
    input  aluop, reg1, reg2, flush, ex_stall, div_result, div_ready,
    output div_opdata1, div_opdata2, div_start, div_annul, signed_div,
           stallreq, whilo, hi, lo
  );

endinterface

// File: rtl/div_ctrl.sv
// EX-stage divider sequencer: issues DIV/DIVU, stalls EX until the result
// returns, then presents {remainder, quotient} as a one-shot HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  div_ctrl_state_t  state_reg, state_next;
  logic             abort_cnt_reg, abort_cnt_next;
  logic [REG_W-1:0] opdata1_reg, opdata1_next;
  logic [REG_W-1:0] opdata2_reg, opdata2_next;
  logic             signed_reg, signed_next;
  logic             start_reg, start_next;
  logic [REG_W-1:0] hi_reg, hi_next;
  logic [REG_W-1:0] lo_reg, lo_next;
  logic             stallreq_next;
  logic             whilo_next;
  logic             is_div;

  assign is_div = is_div_op(bus.aluop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= DIV_CTRL_IDLE;
      abort_cnt_reg <= 1'b0;
      opdata1_reg   <= '0;
      opdata2_reg   <= '0;
      signed_reg    <= 1'b0;
      start_reg     <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      abort_cnt_reg <= abort_cnt_next;
      opdata1_reg   <= opdata1_next;
      opdata2_reg   <= opdata2_next;
      signed_reg    <= signed_next;
      start_reg     <= start_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    abort_cnt_next = abort_cnt_reg;
    opdata1_next   = opdata1_reg;
    opdata2_next   = opdata2_reg;
    signed_next    = signed_reg;
    start_next     = start_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    stallreq_next  = 1'b0;
    whilo_next     = 1'b0;

    case (state_reg)
      DIV_CTRL_IDLE: begin
        stallreq_next = is_div && !bus.flush;
        if (is_div && !bus.flush) begin
          opdata1_next = bus.reg1;
          opdata2_next = bus.reg2;
          signed_next  = (bus.aluop == EXE_DIV_OP);
          start_next   = 1'b1;
          state_next   = DIV_CTRL_BUSY;
        end
      end

      DIV_CTRL_BUSY: begin
        stallreq_next = 1'b1;
        // A flush beats a result arriving in the same cycle
        if (bus.flush) begin
          start_next     = 1'b0;
          abort_cnt_next = 1'b0;
          state_next     = DIV_CTRL_ABORT;
        end else if (bus.div_ready) begin
          hi_next    = bus.div_result[DREG_W-1:REG_W];
          lo_next    = bus.div_result[REG_W-1:0];
          start_next = 1'b0;
          state_next = DIV_CTRL_HOLD;
        end
      end

      DIV_CTRL_HOLD: begin
        whilo_next = !bus.flush;
        if (!bus.ex_stall || bus.flush) begin
          hi_next    = '0;
          lo_next    = '0;
          state_next = DIV_CTRL_IDLE;
        end
      end

      DIV_CTRL_ABORT: begin
        // Two start-low cycles let the divider fall back to its free state
        stallreq_next = is_div;
        if (abort_cnt_reg) begin
          abort_cnt_next = 1'b0;
          state_next     = DIV_CTRL_IDLE;
        end else begin
          abort_cnt_next = 1'b1;
        end
      end

      default: state_next = DIV_CTRL_IDLE;
    endcase
  end

  assign bus.div_opdata1 = opdata1_reg;
  assign bus.div_opdata2 = opdata2_reg;
  assign bus.signed_div  = signed_reg;
  assign bus.div_start   = start_reg;
  assign bus.div_annul   = bus.flush && (state_reg != DIV_CTRL_IDLE);
  assign bus.stallreq    = stallreq_next;
  assign bus.whilo       = whilo_next;
  assign bus.hi          = (state_reg == DIV_CTRL_HOLD) ? hi_reg : '0;
  assign bus.lo          = (state_reg == DIV_CTRL_HOLD) ? lo_reg : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural multi-cycle divider beside it.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int lat_cfg = 5;
  int whilo_total = 0;

  // Divider model: 0 free, 1 by-zero, 2 running, 3 end
  int          dstate = 0;
  int          dcnt = 0;
  logic [63:0] dres = '0;

  function automatic logic [63:0] hw_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q;
    logic [32:0] r;
    if (b == 0) return 64'd0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    r = '0;
    q = '0;
    for (int i = 31; i >= 0; i--) begin
      r = {r[31:0], ma[i]};
      if (r >= {1'b0, mb}) begin
        r = r - {1'b0, mb};
        q[i] = 1'b1;
      end
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r[31:0] = -r[31:0];
    return {r[31:0], q};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dstate         <= 0;
      bus.div_ready  <= 1'b0;
      bus.div_result <= '0;
    end else begin
      case (dstate)
        0: if (bus.div_start && !bus.div_annul) begin
          if (bus.div_opdata2 == 0) dstate <= 1;
          else begin
            dstate <= 2;
            dcnt   <= lat_cfg;
            dres   <= hw_div(bus.signed_div, bus.div_opdata1, bus.div_opdata2);
          end
        end
        1: begin
          bus.div_result <= '0;
          bus.div_ready  <= 1'b1;
          dstate         <= 3;
        end
        2: if (bus.div_annul) dstate <= 0;
           else if (dcnt <= 1) begin
             bus.div_result <= dres;
             bus.div_ready  <= 1'b1;
             dstate         <= 3;
           end else dcnt <= dcnt - 1;
        default: if (!bus.div_start) begin
          bus.div_ready  <= 1'b0;
          bus.div_result <= '0;
          dstate         <= 0;
        end
      endcase
    end
  end

  always @(posedge clk) if (bus.whilo) whilo_total++;

  function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 0) return 64'd0;
    la = (op == EXE_DIV_OP) ? longint'($signed(a)) : longint'(a);
    lb = (op == EXE_DIV_OP) ? longint'($signed(b)) : longint'(b);
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("div_free_at_issue", 64'(dstate), 64'd0);
    bus.aluop = op; bus.reg1 = a; bus.reg2 = b; bus.flush = 1'b0; bus.ex_stall = 1'b0;
    #1;
    chk("stallreq_first", 64'(bus.stallreq), 64'd1);
    @(negedge clk); #1;
    chk("start", 64'(bus.div_start), 64'd1);
    chk("opdata1", 64'(bus.div_opdata1), 64'(a));
    chk("opdata2", 64'(bus.div_opdata2), 64'(b));
    chk("signed_div", 64'(bus.signed_div), 64'(op == EXE_DIV_OP));
  endtask

  task automatic complete(input logic [31:0] ehi, input logic [31:0] elo, input int stall);
    int cyc = 0, gaps = 0, wcnt = 0, unstable = 0;
    while (!bus.whilo && cyc < 500) begin
      if (!bus.stallreq) gaps++;
      @(negedge clk); #1;
      cyc++;
    end
    if (!bus.whilo) begin
      chk("result_timeout", 64'd0, 64'd1);
      bus.aluop = 8'h00;
      return;
    end
    chk("stall_gap", 64'(gaps), 64'd0);
    chk("hi", 64'(bus.hi), 64'(ehi));
    chk("lo", 64'(bus.lo), 64'(elo));
    chk("stallreq_hold", 64'(bus.stallreq), 64'd0);
    chk("start_low_hold", 64'(bus.div_start), 64'd0);
    for (int k = 0; k <= stall; k++) begin
      if (bus.whilo) wcnt++;
      if (bus.hi !== ehi || bus.lo !== elo) unstable++;
      bus.ex_stall = (k < stall);
      @(negedge clk); #1;
    end
    bus.ex_stall = 1'b0;
    bus.aluop = 8'h00;
    chk("whilo_len", 64'(wcnt), 64'(stall + 1));
    chk("hilo_stable", 64'(unstable), 64'd0);
    chk("whilo_off", 64'(bus.whilo), 64'd0);
    chk("hi_off", 64'(bus.hi), 64'd0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input logic [31:0] ehi,
                         input logic [31:0] elo, input int lat);
    lat_cfg = lat;
    issue(op, a, b);
    complete(ehi, elo, stall);
    $display("%s op=%s a=%h b=%h stall=%0d exp hi=%h lo=%h", tag,
             (op == EXE_DIV_OP) ? "DIV " : "DIVU", a, b, stall, ehi, elo);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 64'(bus.div_start), 64'd0);
    chk({tag, "_signed"}, 64'(bus.signed_div), 64'd0);
    chk({tag, "_op1"}, 64'(bus.div_opdata1), 64'd0);
    chk({tag, "_op2"}, 64'(bus.div_opdata2), 64'd0);
    chk({tag, "_whilo"}, 64'(bus.whilo), 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, 64'd0);
    chk({tag, "_stallreq"}, 64'(bus.stallreq), 64'd0);
    chk({tag, "_annul"}, 64'(bus.div_annul), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b;
    int          stall;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int w0;
    logic [63:0] e;
    logic [7:0] op;
    logic [31:0] a, b;
    int sel;

    bus.aluop = 8'h00; bus.reg1 = '0; bus.reg2 = '0;
    bus.flush = 1'b0; bus.ex_stall = 1'b0;

    tbl[0] = '{EXE_DIV_OP,  32'd100,        32'd7, 0, 32'd2,        32'd14,         6};
    tbl[1] = '{EXE_DIV_OP,  -32'sd7,        32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD,   3};
    tbl[2] = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'd1, 0, 32'd0,        32'hFFFFFFFF,   1};
    tbl[3] = '{EXE_DIV_OP,  32'd5,          32'd0, 0, 32'd0,        32'd0,          4};
    tbl[4] = '{EXE_DIVU_OP, 32'd9,          32'd4, 0, 32'd1,        32'd2,          2};
    tbl[5] = '{EXE_DIV_OP,  32'd100,        32'd7, 3, 32'd2,        32'd14,         8};

    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec($sformatf("table%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].stall, tbl[i].hi, tbl[i].lo, tbl[i].lat);

    // Flush on the 10th BUSY cycle, then a fresh DIV through ABORT
    w0 = whilo_total;
    lat_cfg = 40;
    issue(EXE_DIV_OP, 32'd1000, 32'd3);
    repeat (9) begin @(negedge clk); #1; end
    bus.flush = 1'b1;
    #1;
    chk("flush_annul", 64'(bus.div_annul), 64'd1);
    chk("flush_whilo", 64'(bus.whilo), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0; bus.aluop = EXE_DIV_OP; bus.reg1 = 32'd20; bus.reg2 = 32'd3;
    lat_cfg = 5;
    #1;
    chk("abort1_start", 64'(bus.div_start), 64'd0);
    chk("abort1_stallreq", 64'(bus.stallreq), 64'd1);
    chk("abort1_annul", 64'(bus.div_annul), 64'd0);
    @(negedge clk); #1;
    chk("abort2_start", 64'(bus.div_start), 64'd0);
    @(negedge clk); #1;
    chk("idle_start", 64'(bus.div_start), 64'd0);
    @(negedge clk); #1;
    chk("reissue_start", 64'(bus.div_start), 64'd1);
    chk("reissue_op1", 64'(bus.div_opdata1), 64'd20);
    complete(32'd2, 32'd6, 0);
    chk("flush_whilo_count", 64'(whilo_total - w0), 64'd1);
    $display("flush op=DIV a=000003e8 b=00000003 then 20/3 exp hi=00000002 lo=00000006");

    // Reset in the middle of BUSY
    lat_cfg = 20;
    issue(EXE_DIV_OP, -32'sd100, 32'd3);
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b1;
    bus.aluop = 8'h00;
    @(negedge clk); #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    $display("reset mid-BUSY op=DIV a=ffffff9c b=00000003");
    run_vec("post_reset", EXE_DIV_OP, -32'sd9, 32'd4, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 7);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 1) ? EXE_DIV_OP : EXE_DIVU_OP;
      a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel < 4) b = $urandom;
      else b = 32'($urandom_range(0, 20)) - 32'd10;
      e = ref_div(op, a, b);
      run_vec($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 2),
              e[63:32], e[31:0], $urandom_range(1, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
